// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus arbitration types: master count, owner index, arbiter states and turn counter.
package yutorina_bus_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;

    typedef logic [1:0] bus_owner_t;
    typedef logic [1:0] turn_cnt_t;

    typedef enum logic [1:0] {
        ARB_STATE_PARK = 2'd0,
        ARB_STATE_OWN  = 2'd1,
        ARB_STATE_TURN = 2'd2
    } arb_state_t;

    // Active-low grant vector with only the selected master's bit low.
    function automatic logic [BUS_MASTER_CH-1:0] grant_onecold(input bus_owner_t idx);
        logic [BUS_MASTER_CH-1:0] g;
        g = '1;
        g[idx] = 1'b0;
        return g;
    endfunction

endpackage

// File: rtl/yutorina_bus_rr_pick.sv
// Round-robin search: first requesting master after the current owner, owner itself excluded.
module yutorina_bus_rr_pick
    import yutorina_bus_arbiter_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] m_req_,
    input  bus_owner_t               owner,
    output bus_owner_t               next,
    output logic                     pending
);

    bus_owner_t cand_idx [BUS_MASTER_CH-1];
    logic [BUS_MASTER_CH-2:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < BUS_MASTER_CH - 1; gi++) begin : g_cand
            assign cand_idx[gi] = owner + 2'(gi + 1);
            assign cand_hit[gi] = ~m_req_[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest hit wins.
    always_comb begin
        next    = owner;
        pending = |cand_hit;
        for (int i = BUS_MASTER_CH - 2; i >= 0; i--) begin
            if (cand_hit[i]) begin
                next = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with grant parking and a programmable turnaround gap.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BUS_MASTER_CH-1:0] m_req_,
    output logic [BUS_MASTER_CH-1:0] m_grnt_,
    output logic [1:0]               owner,
    output logic                     bus_idle
);

    localparam turn_cnt_t TURN_LOAD = (TURN_CYCLES > 0) ? turn_cnt_t'(TURN_CYCLES - 1) : '0;

    arb_state_t               state_reg;
    bus_owner_t               owner_reg;
    logic [BUS_MASTER_CH-1:0] grnt_reg;
    logic                     idle_reg;
    turn_cnt_t                cnt_reg;

    bus_owner_t next_owner;
    logic       others_pending;
    logic       owner_req;
    logic       do_handover;

    yutorina_bus_rr_pick u_pick (
        .m_req_  (m_req_),
        .owner   (owner_reg),
        .next    (next_owner),
        .pending (others_pending)
    );

    assign owner_req = ~m_req_[owner_reg];

    // Both PARK and OWN hand the bus over as soon as the owner is not asking and someone else is.
    assign do_handover = (state_reg != ARB_STATE_TURN) && !owner_req && others_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB_STATE_PARK;
            owner_reg <= '0;
            grnt_reg  <= grant_onecold(2'd0);
            idle_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else if (do_handover) begin
            owner_reg <= next_owner;
            idle_reg  <= 1'b0;
            if (TURN_CYCLES == 0) begin
                state_reg <= ARB_STATE_OWN;
                grnt_reg  <= grant_onecold(next_owner);
            end else begin
                state_reg <= ARB_STATE_TURN;
                grnt_reg  <= '1;
                cnt_reg   <= TURN_LOAD;
            end
        end else begin
            case (state_reg)
                ARB_STATE_PARK: begin
                    if (owner_req) begin
                        state_reg <= ARB_STATE_OWN;
                        idle_reg  <= 1'b0;
                    end
                end
                ARB_STATE_OWN: begin
                    if (!owner_req) begin
                        state_reg <= ARB_STATE_PARK;
                        idle_reg  <= 1'b1;
                    end
                end
                ARB_STATE_TURN: begin
                    // Target was latched on entry; it is granted even if it has since withdrawn.
                    if (cnt_reg == '0) begin
                        state_reg <= ARB_STATE_OWN;
                        grnt_reg  <= grant_onecold(owner_reg);
                        idle_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ARB_STATE_PARK;
                    owner_reg <= '0;
                    grnt_reg  <= grant_onecold(2'd0);
                    idle_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign m_grnt_  = grnt_reg;
    assign owner    = owner_reg;
    assign bus_idle = idle_reg;

    a_one_grant: assert property (@(posedge clk) disable iff (rst) $countones(~grnt_reg) <= 1);

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Scoreboard bench: three arbiters (turn gap 0, 1, 3) share stimulus and are checked against a queue-fed model.
module tb_yutorina_bus_arbiter;

    localparam int NI = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         m_req_;
    logic [NI-1:0][3:0] grnt;
    logic [NI-1:0][1:0] own;
    logic [NI-1:0]      idle;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int TC = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
            yutorina_bus_arbiter #(.TURN_CYCLES(TC)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .m_req_   (m_req_),
                .m_grnt_  (grnt[gi]),
                .owner    (own[gi]),
                .bus_idle (idle[gi])
            );
        end
    endgenerate

    typedef struct packed {
        int                 due;
        logic [NI-1:0][3:0] grnt;
        logic [NI-1:0][1:0] own;
        logic [NI-1:0]      idle;
    } exp_t;

    exp_t sb [$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Model: who owns (or is about to own) the bus, whether they hold it, and gap cycles left.
    int mo_owner [NI];
    int mo_gap   [NI];
    bit mo_has   [NI];

    function automatic int tc_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic model_step(input int i, input logic [3:0] req, input logic r);
        int nxt;
        bit found;
        if (r) begin
            mo_owner[i] = 0;
            mo_gap[i]   = 0;
            mo_has[i]   = 0;
        end else if (mo_gap[i] > 0) begin
            mo_gap[i] = mo_gap[i] - 1;
            if (mo_gap[i] == 0) mo_has[i] = 1;
        end else begin
            found = 0;
            nxt   = mo_owner[i];
            for (int k = 1; k < 4; k++) begin
                if (!found && !req[(mo_owner[i] + k) % 4]) begin
                    found = 1;
                    nxt   = (mo_owner[i] + k) % 4;
                end
            end
            if (!req[mo_owner[i]]) begin
                mo_has[i] = 1;
            end else if (found) begin
                mo_owner[i] = nxt;
                if (tc_of(i) == 0) begin
                    mo_has[i] = 1;
                    mo_gap[i] = 0;
                end else begin
                    mo_has[i] = 0;
                    mo_gap[i] = tc_of(i);
                end
            end else begin
                mo_has[i] = 0;
            end
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic r);
        exp_t e;
        m_req_ = req;
        rst    = r;
        e.due  = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            model_step(i, req, r);
            e.grnt[i] = (mo_gap[i] > 0) ? 4'hF : ~(4'b0001 << mo_owner[i]);
            e.own[i]  = 2'(mo_owner[i]);
            e.idle[i] = (mo_gap[i] == 0) && !mo_has[i];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (grnt[i] !== e.grnt[i]) begin
                    errors++;
                    $display("FAIL grnt inst%0d cyc=%0d req_=%b got=%b want=%b", i, cyc, m_req_, grnt[i], e.grnt[i]);
                end
                checks++;
                if (own[i] !== e.own[i]) begin
                    errors++;
                    $display("FAIL owner inst%0d cyc=%0d got=%0d want=%0d", i, cyc, own[i], e.own[i]);
                end
                checks++;
                if (idle[i] !== e.idle[i]) begin
                    errors++;
                    $display("FAIL bus_idle inst%0d cyc=%0d got=%b want=%b", i, cyc, idle[i], e.idle[i]);
                end
                checks++;
                if ($countones(~grnt[i]) > 1) begin
                    errors++;
                    $display("FAIL one_grant inst%0d cyc=%0d got=%b want=at most one low", i, cyc, grnt[i]);
                end
            end
        end
    end

    initial begin
        logic [3:0] req;
        logic [3:0] prev;

        // Reset, then parked master 0 requests and releases.
        drive(4'hF, 1'b1);
        drive(4'hF, 1'b1);
        repeat (3) drive(4'hF, 1'b0);
        repeat (3) drive(4'b1110, 1'b0);
        repeat (2) drive(4'hF, 1'b0);

        // Non-owner master 2 requests while parked on 0.
        repeat (5) drive(4'b1011, 1'b0);
        repeat (2) drive(4'hF, 1'b0);

        // Master 3 takes the bus, then all four compete; owners release after one held cycle.
        repeat (5) drive(4'b0111, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);
        for (int s = 0; s < 24; s++) begin
            if (mo_has[1] && mo_gap[1] == 0) drive(4'b0001 << mo_owner[1], 1'b0);
            else drive(4'b0000, 1'b0);
        end
        repeat (2) drive(4'hF, 1'b0);

        // Owner 1 releases on the same edge master 3 requests.
        repeat (5) drive(4'b1101, 1'b0);
        repeat (5) drive(4'b0111, 1'b0);
        repeat (2) drive(4'hF, 1'b0);

        // Turn toward master 2, which withdraws while master 1 asks.
        drive(4'b1011, 1'b0);
        repeat (8) drive(4'b1101, 1'b0);

        // Reset landing in TURN and in OWN.
        drive(4'b1110, 1'b0);
        drive(4'b1110, 1'b1);
        repeat (5) drive(4'b1101, 1'b0);
        drive(4'b1101, 1'b1);
        repeat (2) drive(4'hF, 1'b0);

        // Randomized traffic with sticky requests and rare resets.
        prev = 4'hF;
        for (int s = 0; s < 2000; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 9) >= 4);
            end else begin
                req = prev;
            end
            prev = req;
            drive(req, ($urandom_range(0, 79) == 0));
        end
        repeat (2) drive(4'hF, 1'b0);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
